// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the program counter, drives the combinational
// instruction-ROM word address and captures the fetched word into an IF/ID
// register with a valid bit. Downstream may stall the stage or redirect it
// with a jump or a taken BEQ/BNE. A redirect squashes the wrong-path
// instruction currently being fetched.
//
// Parameters:
//    PC_W      program counter width (byte address); must be at least 29
//    ROM_AW    instruction ROM word-address width
//    RESET_PC  PC loaded on reset (word aligned)
//
// Ports:
//    i_clk        system clock, rising edge
//    i_rst_n      asynchronous active-low reset
//    o_rom_addr   ROM word address, pc[ROM_AW+1:2]
//    i_rom_data   instruction word from ROM, valid in the same cycle
//    i_stall      decode not ready: hold PC and IF/ID
//    i_jump       jump redirect resolved downstream this cycle
//    i_jump_idx   J-type instr_index
//    i_br_taken   taken branch resolved downstream this cycle
//    i_br_imm     signed branch offset in words
//    i_br_pc4     PC+4 of the redirecting instruction
//    o_instr      IF/ID instruction
//    o_pc4        PC+4 of o_instr
//    o_valid      o_instr holds a live instruction
//    o_pc         current fetch PC
//    o_align_err  sticky misaligned-branch-target flag
//                 (present only when FETCH_ALIGN_CHECK_EN is defined)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     ROM_AW   = 6,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [31:0]       i_rom_data,
   input  logic              i_stall,
   input  logic              i_jump,
   input  logic [25:0]       i_jump_idx,
   input  logic              i_br_taken,
   input  logic [15:0]       i_br_imm,
   input  logic [PC_W-1:0]   i_br_pc4,
   output logic [31:0]       o_instr,
   output logic [PC_W-1:0]   o_pc4,
   output logic              o_valid,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic              o_align_err,
`endif
   output logic [PC_W-1:0]   o_pc
);

   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] jump_target;
   logic [PC_W-1:0] br_offset;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] br_target_aligned;
   logic            redirect;

   logic [31:0]     instr_reg;
   logic [PC_W-1:0] pc4_reg;
   logic            valid_reg;

   assign pc_plus4    = pc_reg + PC_W'(4);
   assign jump_target = {i_br_pc4[PC_W-1:28], i_jump_idx, 2'b00};
   // Word offset sign-extended and scaled to bytes; the add wraps mod 2^PC_W.
   assign br_offset   = {{(PC_W-18){i_br_imm[15]}}, i_br_imm, 2'b00};
   assign br_target   = i_br_pc4 + br_offset;
   // A misaligned i_br_pc4 is the only way a target can end up unaligned;
   // the low bits are always dropped so the PC stays word aligned.
   assign br_target_aligned = br_target & ~PC_W'(3);
   assign redirect    = i_jump | i_br_taken;

   // Next-PC priority: jump, taken branch, stall hold, sequential.
   always_comb begin
      pc_next = pc_plus4;
      if (i_jump) begin
         pc_next = jump_target;
      end else if (i_br_taken) begin
         pc_next = br_target_aligned;
      end else if (i_stall) begin
         pc_next = pc_reg;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_reg    <= RESET_PC;
         instr_reg <= 32'h0;
         pc4_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         pc_reg <= pc_next;
         if (redirect) begin
            // Squash the wrong-path fetch: insert a NOP bubble.
            instr_reg <= 32'h0;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
         end else if (!i_stall) begin
            instr_reg <= i_rom_data;
            pc4_reg   <= pc_plus4;
            valid_reg <= 1'b1;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic align_err_reg;

   // Only a branch that actually steers the PC can raise the flag; a jump
   // in the same cycle takes priority and its target is always aligned.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         align_err_reg <= 1'b0;
      end else if (i_br_taken && !i_jump && (br_target[1:0] != 2'b00)) begin
         align_err_reg <= 1'b1;
      end
   end

   assign o_align_err = align_err_reg;
`endif

   // The ROM is smaller than the address space; upper PC bits simply alias.
   assign o_rom_addr = pc_reg[ROM_AW+1:2];
   assign o_instr    = instr_reg;
   assign o_pc4      = pc4_reg;
   assign o_valid    = valid_reg;
   assign o_pc       = pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int PC_W   = 32;
   localparam int ROM_AW = 6;

   logic              clk;
   logic              rst_n;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              stall;
   logic              jump;
   logic [25:0]       jump_idx;
   logic              br_taken;
   logic [15:0]       br_imm;
   logic [PC_W-1:0]   br_pc4;
   logic [31:0]       instr;
   logic [PC_W-1:0]   pc4;
   logic              valid;
   logic [PC_W-1:0]   pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic              align_err;
`endif

   logic [31:0] rom [0:(1<<ROM_AW)-1];
   int n_checks;
   int n_fail;

   fetch_stage #(
      .PC_W(PC_W),
      .ROM_AW(ROM_AW),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .o_rom_addr(rom_addr),
      .i_rom_data(rom_data),
      .i_stall(stall),
      .i_jump(jump),
      .i_jump_idx(jump_idx),
      .i_br_taken(br_taken),
      .i_br_imm(br_imm),
      .i_br_pc4(br_pc4),
      .o_instr(instr),
      .o_pc4(pc4),
      .o_valid(valid),
`ifdef FETCH_ALIGN_CHECK_EN
      .o_align_err(align_err),
`endif
      .o_pc(pc)
   );

   assign rom_data = rom[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      stall    = 1'b0;
      jump     = 1'b0;
      br_taken = 1'b0;
      jump_idx = '0;
      br_imm   = '0;
      br_pc4   = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_ctrl();
      repeat (2) step();
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 00000000", instr); end
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", pc); end
      rst_n = 1'b1;
      step();
      $display("reset release cycle1: instr=%h pc4=%h valid=%0b", instr, pc4, valid);
      n_checks++; if (instr !== 32'h028f1020) begin n_fail++; $display("FAIL rel1_instr got %h want 028f1020", instr); end
      n_checks++; if (pc4 !== 32'h4) begin n_fail++; $display("FAIL rel1_pc4 got %h want 00000004", pc4); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rel1_valid got %0b want 1", valid); end
      step();
      $display("reset release cycle2: instr=%h pc4=%h", instr, pc4);
      n_checks++; if (instr !== 32'h028f1022) begin n_fail++; $display("FAIL rel2_instr got %h want 028f1022", instr); end
      n_checks++; if (pc4 !== 32'h8) begin n_fail++; $display("FAIL rel2_pc4 got %h want 00000008", pc4); end
      step();
      step();
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc got %h want 00000010", pc); end
      n_checks++; if (instr !== 32'hA500_0003) begin n_fail++; $display("FAIL seq_instr got %h want a5000003", instr); end
   endtask

   task automatic test_jump();
      jump = 1'b1; jump_idx = 26'd2; br_pc4 = 32'h14;
      step();
      clear_ctrl();
      $display("jump squash: pc=%h instr=%h valid=%0b", pc, instr, valid);
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL jump_squash_valid got %0b want 0", valid); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL jump_squash_instr got %h want 00000000", instr); end
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL jump_pc got %h want 00000008", pc); end
      step();
      $display("jump target: instr=%h pc4=%h", instr, pc4);
      n_checks++; if (instr !== 32'hA500_0002) begin n_fail++; $display("FAIL jump_tgt_instr got %h want a5000002", instr); end
      n_checks++; if (pc4 !== 32'hC) begin n_fail++; $display("FAIL jump_tgt_pc4 got %h want 0000000c", pc4); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL jump_tgt_valid got %0b want 1", valid); end
   endtask

   task automatic test_branch();
      br_taken = 1'b1; br_imm = 16'hFFFE; br_pc4 = 32'h14;
      step();
      clear_ctrl();
      $display("branch squash: pc=%h valid=%0b", pc, valid);
      n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL br_pc got %h want 0000000c", pc); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_squash_valid got %0b want 0", valid); end
      step();
      $display("branch target: instr=%h pc4=%h", instr, pc4);
      n_checks++; if (instr !== 32'hA500_0003) begin n_fail++; $display("FAIL br_tgt_instr got %h want a5000003", instr); end
      n_checks++; if (pc4 !== 32'h10) begin n_fail++; $display("FAIL br_tgt_pc4 got %h want 00000010", pc4); end
   endtask

   task automatic test_stall();
      jump = 1'b1; jump_idx = 26'd1; br_pc4 = 32'h14;
      step();
      clear_ctrl();
      step();
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_setup_pc got %h want 00000008", pc); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         $display("stall cycle %0d: pc=%h addr=%0d instr=%h pc4=%h valid=%0b", i, pc, rom_addr, instr, pc4, valid);
         n_checks++; if (rom_addr !== 6'd2) begin n_fail++; $display("FAIL stall_addr got %0d want 2", rom_addr); end
         n_checks++; if (instr !== 32'h028f1022) begin n_fail++; $display("FAIL stall_instr got %h want 028f1022", instr); end
         n_checks++; if (pc4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc4 got %h want 00000008", pc4); end
         n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %0b want 1", valid); end
      end
      stall = 1'b0;
      step();
      $display("stall release: pc=%h instr=%h", pc, instr);
      n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_rel_pc got %h want 0000000c", pc); end
      n_checks++; if (instr !== 32'hA500_0002) begin n_fail++; $display("FAIL stall_rel_instr got %h want a5000002", instr); end
   endtask

   task automatic test_stall_redirect();
      stall = 1'b1; br_taken = 1'b1; br_imm = 16'd2; br_pc4 = 32'h8;
      step();
      clear_ctrl();
      $display("stall+branch: pc=%h valid=%0b", pc, valid);
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL sr_pc got %h want 00000010", pc); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL sr_valid got %0b want 0", valid); end
      step();
      n_checks++; if (instr !== 32'hA500_0004) begin n_fail++; $display("FAIL sr_tgt_instr got %h want a5000004", instr); end
   endtask

   task automatic test_jump_priority();
      jump = 1'b1; jump_idx = 26'd5; br_taken = 1'b1; br_imm = 16'd7; br_pc4 = 32'h10;
      step();
      clear_ctrl();
      $display("jump+branch: pc=%h valid=%0b", pc, valid);
      n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL prio_pc got %h want 00000014", pc); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid got %0b want 0", valid); end
      step();
      n_checks++; if (instr !== 32'hA500_0005) begin n_fail++; $display("FAIL prio_instr got %h want a5000005", instr); end
      jump = 1'b1; jump_idx = 26'd3; br_pc4 = 32'hF000_0010;
      step();
      clear_ctrl();
      $display("jump upper bits: pc=%h addr=%0d", pc, rom_addr);
      n_checks++; if (pc !== 32'hF000_000C) begin n_fail++; $display("FAIL jhi_pc got %h want f000000c", pc); end
      n_checks++; if (rom_addr !== 6'd3) begin n_fail++; $display("FAIL jhi_addr got %0d want 3", rom_addr); end
      step();
      n_checks++; if (pc4 !== 32'hF000_0010) begin n_fail++; $display("FAIL jhi_pc4 got %h want f0000010", pc4); end
   endtask

   task automatic test_wrap();
      br_taken = 1'b1; br_imm = 16'hFFFE; br_pc4 = 32'h4;
      step();
      clear_ctrl();
      $display("branch wrap: pc=%h addr=%0d", pc, rom_addr);
      n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", pc); end
      n_checks++; if (rom_addr !== 6'd63) begin n_fail++; $display("FAIL wrap_addr got %0d want 63", rom_addr); end
      step();
      $display("pc wrap: pc=%h instr=%h pc4=%h", pc, instr, pc4);
      n_checks++; if (instr !== 32'hA500_003F) begin n_fail++; $display("FAIL wrap_instr got %h want a500003f", instr); end
      n_checks++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 00000000", pc4); end
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next got %h want 00000000", pc); end
      jump = 1'b1; jump_idx = 26'h40; br_pc4 = 32'h0;
      step();
      clear_ctrl();
      n_checks++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL alias_addr got %0d want 0", rom_addr); end
      step();
      $display("rom alias: instr=%h pc4=%h", instr, pc4);
      n_checks++; if (instr !== 32'h028f1020) begin n_fail++; $display("FAIL alias_instr got %h want 028f1020", instr); end
      n_checks++; if (pc4 !== 32'h104) begin n_fail++; $display("FAIL alias_pc4 got %h want 00000104", pc4); end
   endtask

   task automatic test_align();
      br_taken = 1'b1; br_imm = 16'd0; br_pc4 = 32'h15;
      step();
      clear_ctrl();
      $display("misaligned branch: pc=%h", pc);
      n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL align_pc got %h want 00000014", pc); end
`ifdef FETCH_ALIGN_CHECK_EN
      n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL align_err got %0b want 1", align_err); end
`endif
      step();
      n_checks++; if (instr !== 32'hA500_0005) begin n_fail++; $display("FAIL align_instr got %h want a5000005", instr); end
`ifdef FETCH_ALIGN_CHECK_EN
      step();
      n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL align_sticky got %0b want 1", align_err); end
`endif
   endtask

   task automatic test_async_reset();
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got %0b want 1", valid); end
      br_taken = 1'b1; br_imm = 16'd4; br_pc4 = 32'h10;
      #3;
      rst_n = 1'b0;
      #1;
      $display("async reset: pc=%h instr=%h pc4=%h valid=%0b", pc, instr, pc4, valid);
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0b want 0", valid); end
      n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr got %h want 00000000", instr); end
      n_checks++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL arst_pc4 got %h want 00000000", pc4); end
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc got %h want 00000000", pc); end
`ifdef FETCH_ALIGN_CHECK_EN
      n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL arst_align_err got %0b want 0", align_err); end
`endif
      clear_ctrl();
      step();
      rst_n = 1'b1;
      step();
      $display("post reset: instr=%h pc4=%h", instr, pc4);
      n_checks++; if (instr !== 32'h028f1020) begin n_fail++; $display("FAIL arst_rel_instr got %h want 028f1020", instr); end
      n_checks++; if (pc4 !== 32'h4) begin n_fail++; $display("FAIL arst_rel_pc4 got %h want 00000004", pc4); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < (1 << ROM_AW); i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[0] = 32'h028f1020;
      rom[1] = 32'h028f1022;
      test_reset();
      test_jump();
      test_branch();
      test_stall();
      test_stall_redirect();
      test_jump_priority();
      test_wrap();
      test_align();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the core's decode/execute logic.
- Owns the program counter and drives the instruction-ROM word address.
- Captures the fetched word into an IF/ID register with a valid bit.
- Accepts redirects from downstream: a jump, or a taken BEQ/BNE. Supports a downstream stall. On a redirect, the in-flight wrong-path instruction is squashed.

Parameters:
- PC_W, 32, program counter width in bits (byte address).
- ROM_AW, 6, instruction ROM word-address width (64 words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- o_rom_addr  output  ROM_AW  ROM word address = pc[ROM_AW+1:2]; ROM is combinational, data valid same cycle.
- i_rom_data  input  32  instruction word from ROM.
- i_stall  input  1  decode not ready; hold PC and IF/ID contents.
- i_jump  input  1  jump redirect (J, op=2) resolved downstream this cycle.
- i_jump_idx  input  26  J-type instr_index.
- i_br_taken  input  1  taken branch (BEQ/BNE) resolved downstream this cycle.
- i_br_imm  input  16  branch offset, signed, in words.
- i_br_pc4  input  PC_W  PC+4 of the branch instruction.
- o_instr  output  32  registered instruction (IF/ID).
- o_pc4  output  PC_W  registered PC+4 of o_instr.
- o_valid  output  1  o_instr holds a live instruction.
- o_pc  output  PC_W  current fetch PC (debug/visibility).

Behaviour:
- Reset (asynchronous, any time including mid-redirect or mid-stall):
  - pc = RESET_PC; o_instr = 32'h0; o_pc4 = 0; o_valid = 0.
  - First valid instruction appears on o_instr one rising edge after release.
- next_pc priority, highest first:
  - i_jump: {i_br_pc4[PC_W-1:28], i_jump_idx, 2'b00}. PC+4 upper bits come from i_br_pc4, which downstream drives with the jump's PC+4.
  - i_br_taken: i_br_pc4 + (sign_extend(i_br_imm) << 2), modulo 2^PC_W, wrap allowed.
  - i_stall: pc (hold).
  - Otherwise: pc + 4, wrapping at 2^PC_W.
- Redirect vs. stall:
  - A redirect overrides i_stall for PC update.
  - On redirect the IF/ID register is squashed: o_valid = 0 next cycle, o_instr = 32'h0 (NOP).
  - i_jump and i_br_taken asserted together: jump wins, single squash.
- Stall without redirect: o_instr, o_pc4 and o_valid are held unchanged. The ROM address stays constant.
- Normal cycle: o_instr <= i_rom_data; o_pc4 <= pc + 4; o_valid <= 1.
- Latency:
  - PC to o_instr: 1 cycle.
  - Redirect to first target instruction valid on o_instr: 2 cycles (1 bubble).
- ROM address wraps naturally: PC beyond the ROM depth aliases to pc[ROM_AW+1:2], with no error.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output o_align_err (1 bit, reset 0).
  - If a branch target has pc[1:0] != 0 (only possible with a misaligned i_br_pc4), the target is forced aligned (low bits cleared) and o_align_err is set.
  - o_align_err is sticky until reset.
- Undefined:
  - Port absent.
  - Low two PC bits are always written as 0 with no check.

Test Plan:
- Reset release with ROM[0]=028f1020 (ADD), ROM[1]=028f1022 (SUB) -> cycle 1: o_instr=028f1020, o_pc4=4, o_valid=1; cycle 2: o_instr=028f1022, o_pc4=8.
- Jump: at PC 0x10 assert i_jump with i_jump_idx=2, i_br_pc4=0x14 -> next cycle o_valid=0, o_instr=0; pc=0x08; following cycle o_instr=ROM[2], o_pc4=0x0C.
- Taken branch: i_br_taken, i_br_imm=16'hfffe, i_br_pc4=0x14 -> pc=0x0C, one bubble, then o_instr=ROM[3].
- Stall 3 cycles at pc=0x08 -> o_rom_addr=2 and o_instr/o_pc4/o_valid constant for all 3 cycles; after release pc advances to 0x0C.
- Stall and i_br_taken in the same cycle (imm=2, pc4=0x08) -> redirect wins: pc=0x10, o_valid=0 next cycle.
- Assert i_rst_n=0 mid-cycle during a redirect -> outputs clear immediately without a clock; pc=RESET_PC. With FETCH_ALIGN_CHECK_EN: i_br_pc4=0x15, imm=0 -> pc=0x14, o_align_err=1 and stays set.
